qam_symbol_scheduler: RTL and testbench

Symbol-timing controller for the QAM modem datapath. It buffers incoming 2-bit symbols in a small FIFO and presents one symbol to the QAM mixer per symbol period. It also generates the mixer sample-enable tick and a mid-symbol capture strobe for the QAM demodulator, and returns the captured demodulated symbol. It sits between the symbol source and the qam_mixer/qam_demodulator pair, replacing free-running divide counters with a sequenced, flow-controlled scheduler.

---
 rtl/qam_symbol_scheduler.sv | 179 +++++++++++++++++
 tb/tb_qam_symbol_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: buffers 2-bit source symbols in a small FIFO and
// releases one per symbol period to the QAM mixer. It also generates the mixer
// sample tick, the first-cycle symbol strobe and the mid-symbol demodulator
// capture strobe, and returns the captured demodulated symbol.
module qam_symbol_scheduler #(
  parameter int MIXER_DIV  = 8,
  parameter int SYMBOL_LEN = 1000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [1:0]                    sym_in,
  input  logic                          sym_valid,
  output logic                          sym_ready,
  output logic [1:0]                    sym_out,
  output logic                          sym_strobe,
  output logic                          mixer_tick,
  input  logic [1:0]                    demod_in,
  output logic                          demod_sample,
  output logic [1:0]                    demod_sym,
  output logic                          demod_valid,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);

  localparam int CW = $clog2(SYMBOL_LEN);
  localparam int MW = $clog2(MIXER_DIV);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(SYMBOL_LEN - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(SYMBOL_LEN / 2);
  localparam logic [MW-1:0] MIX_LAST = MW'(MIXER_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [1:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [MW-1:0]   r_mix;
  logic [MW-1:0]   w_mix_nxt;
  logic [1:0]      r_sym_out;
  logic [1:0]      w_sym_nxt;
  logic            r_sym_strobe;
  logic            r_mixer_tick;
  logic            r_demod_sample;
  logic [1:0]      r_demod_sym;
  logic            r_demod_valid;
  logic            r_underflow;
  logic            w_uflow_set;
  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic            w_nonempty;
  logic [1:0]      w_head;

  assign w_ready    = (r_level < LVL_FULL);
  assign w_push     = sym_valid && w_ready;
  assign w_nonempty = (r_level != '0);
  assign w_head     = r_mem[r_rd_ptr];

  assign sym_ready    = w_ready;
  assign sym_out      = r_sym_out;
  assign sym_strobe   = r_sym_strobe;
  assign mixer_tick   = r_mixer_tick;
  assign demod_sample = r_demod_sample;
  assign demod_sym    = r_demod_sym;
  assign demod_valid  = r_demod_valid;
  assign underflow    = r_underflow;
  assign fifo_level   = r_level;
  assign busy         = (r_state == S_RUN);

  // FIFO storage; contents need no reset because the pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sym_in;
  end

  // FIFO pointers and occupancy; pop decision comes from the scheduler FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state, counters, symbol selection and FIFO pop at symbol boundaries.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_mix_nxt   = '0;
    w_sym_nxt   = '0;
    w_pop       = 1'b0;
    w_uflow_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable && w_nonempty) begin
          w_state_nxt = S_RUN;
          w_pop       = 1'b1;
          w_sym_nxt   = w_head;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          // Enable is only consulted here, so a started symbol always completes.
          if (!enable) begin
            w_state_nxt = S_IDLE;
          end else if (w_nonempty) begin
            w_pop     = 1'b1;
            w_sym_nxt = w_head;
          end else begin
            w_uflow_set = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
          w_mix_nxt = (r_mix == MIX_LAST) ? '0 : r_mix + MW'(1);
          w_sym_nxt = r_sym_out;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered timing outputs derived from next-cycle counter values so they
  // line up with the counter position they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_mix          <= '0;
      r_sym_out      <= '0;
      r_sym_strobe   <= 1'b0;
      r_mixer_tick   <= 1'b0;
      r_demod_sample <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_cnt          <= w_cnt_nxt;
      r_mix          <= w_mix_nxt;
      r_sym_out      <= w_sym_nxt;
      r_sym_strobe   <= (w_state_nxt == S_RUN) && (w_cnt_nxt == '0);
      r_mixer_tick   <= (w_state_nxt == S_RUN) && (w_mix_nxt == '0);
      r_demod_sample <= (w_state_nxt == S_RUN) && (w_cnt_nxt == CNT_HALF);
      if (w_uflow_set) r_underflow <= 1'b1;
    end
  end

  // Demodulator capture on the edge that ends the sample cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_demod_sym   <= '0;
      r_demod_valid <= 1'b0;
    end else begin
      r_demod_valid <= r_demod_sample;
      if (r_demod_sample) r_demod_sym <= demod_in;
    end
  end

endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// Directed testbench for qam_symbol_scheduler (MIXER_DIV=8, SYMBOL_LEN=32,
// FIFO_DEPTH=4): a checkpoint table for start-up, one full symbol and an
// underflow, plus hand sequences for reset, backpressure, stop and capture.
module tb_qam_symbol_scheduler;

  localparam int MD = 8;
  localparam int SL = 32;
  localparam int FD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [1:0] sym_in = 2'b00;
  logic       sym_valid = 1'b0;
  logic [1:0] demod_in = 2'b00;
  logic       sym_ready;
  logic [1:0] sym_out;
  logic       sym_strobe;
  logic       mixer_tick;
  logic       demod_sample;
  logic [1:0] demod_sym;
  logic       demod_valid;
  logic       underflow;
  logic [2:0] fifo_level;
  logic       busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    logic        en;
    logic        valid;
    logic [1:0]  sym;
    logic [1:0]  demod;
    int unsigned n;
    logic [1:0]  e_sym;
    logic        e_strobe;
    logic        e_tick;
    logic        e_sample;
    logic        e_dvalid;
    logic [1:0]  e_dsym;
    logic        e_busy;
    logic [2:0]  e_level;
    logic        e_ready;
    logic        e_uflow;
  } vec_t;

  vec_t vecs [15];

  qam_symbol_scheduler #(
    .MIXER_DIV (MD),
    .SYMBOL_LEN(SL),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sym_in      (sym_in),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_out     (sym_out),
    .sym_strobe  (sym_strobe),
    .mixer_tick  (mixer_tick),
    .demod_in    (demod_in),
    .demod_sample(demod_sample),
    .demod_sym   (demod_sym),
    .demod_valid (demod_valid),
    .underflow   (underflow),
    .fifo_level  (fifo_level),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, ".sym_out"},      32'(sym_out),      32'(v.e_sym));
    chk({tag, ".sym_strobe"},   32'(sym_strobe),   32'(v.e_strobe));
    chk({tag, ".mixer_tick"},   32'(mixer_tick),   32'(v.e_tick));
    chk({tag, ".demod_sample"}, 32'(demod_sample), 32'(v.e_sample));
    chk({tag, ".demod_valid"},  32'(demod_valid),  32'(v.e_dvalid));
    chk({tag, ".demod_sym"},    32'(demod_sym),    32'(v.e_dsym));
    chk({tag, ".busy"},         32'(busy),         32'(v.e_busy));
    chk({tag, ".fifo_level"},   32'(fifo_level),   32'(v.e_level));
    chk({tag, ".sym_ready"},    32'(sym_ready),    32'(v.e_ready));
    chk({tag, ".underflow"},    32'(underflow),    32'(v.e_uflow));
  endtask

  initial begin
    logic [1:0] bp_syms [5];
    logic [1:0] bp_order [4];

    //            en    valid sym    demod  n      e_sym  stb   tick  samp  dval  e_dsym busy  lvl   rdy   uflow
    vecs[0]  = '{1'b1, 1'b1, 2'b01, 2'b11, 32'd1,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 3'd1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 2'b10, 2'b11, 32'd1,  2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd7,  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd7,  2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd6,  2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd7,  2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'd0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd31, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 3'd0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 2'b00, 2'b11, 32'd1,  2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'd0, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 2'b00, 2'b11, 32'd32, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 2'b00, 2'b11, 32'd5,  2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 3'd0, 1'b1, 1'b1};

    bp_syms[0] = 2'b01; bp_syms[1] = 2'b10; bp_syms[2] = 2'b11; bp_syms[3] = 2'b00; bp_syms[4] = 2'b01;
    bp_order[0] = 2'b10; bp_order[1] = 2'b11; bp_order[2] = 2'b00; bp_order[3] = 2'b01;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst0.sym_out",    32'(sym_out),    32'd0);
    chk("rst0.sym_strobe", 32'(sym_strobe), 32'd0);
    chk("rst0.mixer_tick", 32'(mixer_tick), 32'd0);
    chk("rst0.busy",       32'(busy),       32'd0);
    chk("rst0.fifo_level", 32'(fifo_level), 32'd0);
    chk("rst0.sym_ready",  32'(sym_ready),  32'd1);
    chk("rst0.underflow",  32'(underflow),  32'd0);
    chk("rst0.demod_sym",  32'(demod_sym),  32'd0);
    step(2);
    rst = 1'b0;

    // Checkpoint table: start-up, one full symbol period, underflow, stop.
    for (int i = 0; i < 15; i++) begin
      enable    = vecs[i].en;
      sym_valid = vecs[i].valid;
      sym_in    = vecs[i].sym;
      demod_in  = vecs[i].demod;
      step(vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset asserted between clock edges while running with a non-empty FIFO.
    enable = 1'b1; sym_valid = 1'b1; sym_in = 2'b11;
    step(1);
    sym_in = 2'b10;
    step(1);
    sym_in = 2'b01;
    step(1);
    sym_valid = 1'b0;
    step(3);
    chk("midrst.pre_busy",  32'(busy),       32'd1);
    chk("midrst.pre_level", 32'(fifo_level), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("midrst.busy",        32'(busy),        32'd0);
    chk("midrst.fifo_level",  32'(fifo_level),  32'd0);
    chk("midrst.sym_out",     32'(sym_out),     32'd0);
    chk("midrst.sym_ready",   32'(sym_ready),   32'd1);
    chk("midrst.underflow",   32'(underflow),   32'd0);
    chk("midrst.demod_sym",   32'(demod_sym),   32'd0);
    chk("midrst.mixer_tick",  32'(mixer_tick),  32'd0);
    step(1);
    rst = 1'b0;

    // Backpressure: fill the FIFO while disabled, hold the fifth symbol.
    enable = 1'b0; sym_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sym_in = bp_syms[i];
      step(1);
      chk($sformatf("bp.level%0d", i), 32'(fifo_level), 32'(i + 1));
    end
    chk("bp.ready_full", 32'(sym_ready), 32'd0);
    sym_in = bp_syms[4];
    step(2);
    chk("bp.level_held", 32'(fifo_level), 32'd4);
    chk("bp.ready_held", 32'(sym_ready),  32'd0);
    chk("bp.idle",       32'(busy),       32'd0);
    enable = 1'b1;
    step(1);
    chk("bp.start_busy",   32'(busy),       32'd1);
    chk("bp.start_sym",    32'(sym_out),    32'(bp_syms[0]));
    chk("bp.start_strobe", 32'(sym_strobe), 32'd1);
    chk("bp.start_level",  32'(fifo_level), 32'd3);
    step(1);
    chk("bp.fifth_push", 32'(fifo_level), 32'd4);
    sym_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(k == 0 ? 31 : 32);
      chk($sformatf("bp.order%0d", k),  32'(sym_out),    32'(bp_order[k]));
      chk($sformatf("bp.strobe%0d", k), 32'(sym_strobe), 32'd1);
      chk($sformatf("bp.lvl%0d", k),    32'(fifo_level), 32'(3 - k));
    end

    // Stop: enable drops mid-symbol with two symbols queued.
    sym_valid = 1'b1; sym_in = 2'b10;
    step(1);
    sym_in = 2'b11;
    step(1);
    sym_valid = 1'b0;
    step(3);
    enable = 1'b0;
    step(26);
    chk("stop.last_busy",  32'(busy),       32'd1);
    chk("stop.last_sym",   32'(sym_out),    32'd1);
    chk("stop.last_level", 32'(fifo_level), 32'd2);
    step(1);
    chk("stop.busy",   32'(busy),       32'd0);
    chk("stop.sym",    32'(sym_out),    32'd0);
    chk("stop.strobe", 32'(sym_strobe), 32'd0);
    chk("stop.level",  32'(fifo_level), 32'd2);
    for (int c = 0; c < 12; c++) begin
      chk($sformatf("stop.tick%0d", c), 32'(mixer_tick), 32'd0);
      step(1);
    end
    chk("stop.level_after", 32'(fifo_level), 32'd2);

    // Underflow with symbol 11, demod capture of 10, sticky flag.
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("uf.clr_uflow", 32'(underflow),  32'd0);
    chk("uf.clr_level", 32'(fifo_level), 32'd0);
    enable = 1'b1; sym_valid = 1'b1; sym_in = 2'b11; demod_in = 2'b10;
    step(1);
    sym_valid = 1'b0;
    step(1);
    chk("uf.first_sym",    32'(sym_out),    32'd3);
    chk("uf.first_strobe", 32'(sym_strobe), 32'd1);
    chk("uf.first_uflow",  32'(underflow),  32'd0);
    step(17);
    chk("uf.dvalid", 32'(demod_valid), 32'd1);
    chk("uf.dsym",   32'(demod_sym),   32'd2);
    step(15);
    chk("uf.sym_zero", 32'(sym_out),    32'd0);
    chk("uf.strobe",   32'(sym_strobe), 32'd1);
    chk("uf.flag",     32'(underflow),  32'd1);
    chk("uf.busy",     32'(busy),       32'd1);
    sym_valid = 1'b1; sym_in = 2'b10;
    step(1);
    sym_valid = 1'b0;
    chk("uf.push_level", 32'(fifo_level), 32'd1);
    chk("uf.sticky0",    32'(underflow),  32'd1);
    step(31);
    chk("uf.next_sym",    32'(sym_out),    32'd2);
    chk("uf.next_strobe", 32'(sym_strobe), 32'd1);
    chk("uf.sticky1",     32'(underflow),  32'd1);
    chk("uf.next_level",  32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
